// File: rtl/mbf_pkg.sv
// Shared definitions for the MBF band-merge slice.
//   DW       - sample width, equal to the MBF y/z width
//   DEPTH    - default per-band FIFO depth
//   N_PAIRS  - LPF/HPF pairs per frame
//   IW       - pair index width
//   BAND_*   - out_band encoding
//   sel_state_t - band selector state type
package mbf_pkg;

   localparam int DW      = 8;
   localparam int DEPTH   = 4;
   localparam int N_PAIRS = 527;
   localparam int IW      = 10;

   localparam logic BAND_LPF = 1'b0;
   localparam logic BAND_HPF = 1'b1;

   // Encoded so that the state value equals the band it selects.
   typedef enum logic {
      SEL_L = 1'b0,
      SEL_H = 1'b1
   } sel_state_t;

endpackage

// File: rtl/mbf_sync_fifo.sv
// Small synchronous FIFO used once per MBF sub-band.
// Ports:
//   clk, reset   - rising-edge clock, synchronous active-high reset
//   push, din    - write request and data; ignored when full unless popped
//                  in the same cycle
//   pop          - remove the head word (ignored when empty)
//   dout         - head word (combinational from storage, no fall-through)
//   full, empty  - occupancy status
module mbf_sync_fifo #(
   parameter int DEPTH = 4,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout,
   output logic          full,
   output logic          empty
);

   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          wr_en;
   logic          rd_en;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);

   // A full FIFO can still take a word when the head leaves in the same cycle.
   assign wr_en = push & (~full | pop);
   assign rd_en = pop & ~empty;
   assign dout  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({wr_en, rd_en})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mbf_band_merge.sv
// Merges the MBF LPF (y) and HPF (z) sub-band streams into one interleaved,
// back-pressurable stream: LPF0, HPF0, LPF1, HPF1, ...
// Each band is buffered in its own FIFO; the selector strictly alternates.
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-high reset
//   y_valid, y          - LPF sample strobe/data from MBF (cannot stall)
//   z_valid, z          - HPF sample strobe/data from MBF (cannot stall)
//   out_ready           - downstream accepts out_data this cycle
//   out_valid, out_data - merged output word
//   out_band            - 0 = LPF word, 1 = HPF word
//   out_idx             - pair index of the current word
//   y_ovf, z_ovf        - sticky: a sample of that band was dropped
//   done                - sticky: N_PAIRS pairs accepted downstream
// Optional build macro MBF_MERGE_CHECKSUM_EN adds out_sum[15:0], a running
// mod-2^16 sum of accepted words, frozen once done.
//
// state | meaning
// SEL_L | next word loaded comes from the LPF FIFO
// SEL_H | next word loaded comes from the HPF FIFO
module mbf_band_merge #(
   parameter int DW      = mbf_pkg::DW,
   parameter int DEPTH   = mbf_pkg::DEPTH,
   parameter int N_PAIRS = mbf_pkg::N_PAIRS,
   parameter int IW      = mbf_pkg::IW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          y_valid,
   input  logic [DW-1:0] y,
   input  logic          z_valid,
   input  logic [DW-1:0] z,
   input  logic          out_ready,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   output logic          out_band,
   output logic [IW-1:0] out_idx,
   output logic          y_ovf,
   output logic          z_ovf,
   output logic          done
`ifdef MBF_MERGE_CHECKSUM_EN
  ,output logic [15:0]   out_sum
`endif
);

   import mbf_pkg::*;

   // One extra bit so the counter can hold N_PAIRS even when it equals 2**IW.
   localparam int CW = IW + 1;
   localparam logic [CW-1:0] PAIR_LAST = CW'(N_PAIRS - 1);
   localparam logic [CW-1:0] PAIR_END  = CW'(N_PAIRS);

   sel_state_t    sel;
   logic [CW-1:0] pair_cnt;
   logic [CW-1:0] pair_next;

   logic [DW-1:0] y_head;
   logic [DW-1:0] z_head;
   logic          y_full;
   logic          y_empty;
   logic          z_full;
   logic          z_empty;
   logic          y_pop;
   logic          z_pop;

   logic          sel_empty;
   logic          accept;
   logic          hpf_accept;
   logic          last_accept;
   logic          stop;
   logic          load;

   mbf_sync_fifo #(.DEPTH(DEPTH), .DW(DW)) u_y_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (y_valid),
      .pop   (y_pop),
      .din   (y),
      .dout  (y_head),
      .full  (y_full),
      .empty (y_empty)
   );

   mbf_sync_fifo #(.DEPTH(DEPTH), .DW(DW)) u_z_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (z_valid),
      .pop   (z_pop),
      .din   (z),
      .dout  (z_head),
      .full  (z_full),
      .empty (z_empty)
   );

   assign sel_empty   = (sel == SEL_L) ? y_empty : z_empty;
   assign accept      = out_valid & out_ready;
   assign hpf_accept  = accept & (out_band == BAND_HPF);
   assign last_accept = hpf_accept & (pair_cnt == PAIR_LAST);

   // Loads stop from the edge that accepts the final HPF word, so no word of
   // a following pair ever appears on the output while done is pending.
   assign stop = done | (pair_cnt == PAIR_END) | last_accept;
   assign load = (~out_valid | out_ready) & ~stop & ~sel_empty;

   assign y_pop = load & (sel == SEL_L);
   assign z_pop = load & (sel == SEL_H);

   // An LPF word loaded on the edge that retires the previous HPF word
   // belongs to the next pair.
   assign pair_next = pair_cnt + CW'(hpf_accept);

   always_ff @(posedge clk) begin
      if (reset) begin
         sel       <= SEL_L;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_band  <= BAND_LPF;
         out_idx   <= '0;
      end else begin
         if (load) begin
            out_valid <= 1'b1;
            out_data  <= (sel == SEL_L) ? y_head : z_head;
            out_band  <= (sel == SEL_H) ? BAND_HPF : BAND_LPF;
            out_idx   <= pair_next[IW-1:0];
            sel       <= (sel == SEL_L) ? SEL_H : SEL_L;
         end else if (accept) begin
            out_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pair_cnt <= '0;
         done     <= 1'b0;
         y_ovf    <= 1'b0;
         z_ovf    <= 1'b0;
      end else begin
         pair_cnt <= pair_next;
         if (pair_cnt == PAIR_END) begin
            done <= 1'b1;
         end
         if (y_valid & y_full & ~y_pop) begin
            y_ovf <= 1'b1;
         end
         if (z_valid & z_full & ~z_pop) begin
            z_ovf <= 1'b1;
         end
      end
   end

`ifdef MBF_MERGE_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         out_sum <= '0;
      end else if (accept & ~done) begin
         out_sum <= out_sum + 16'(out_data);
      end
   end
`endif

endmodule

// File: tb/tb_mbf_band_merge.sv
module tb_mbf_band_merge;

   localparam int DW      = 8;
   localparam int IW      = 10;
   localparam int N_PAIRS = 527;

   logic          clk = 1'b0;
   logic          reset;
   logic          y_valid;
   logic [DW-1:0] y;
   logic          z_valid;
   logic [DW-1:0] z;
   logic          out_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_band;
   logic [IW-1:0] out_idx;
   logic          y_ovf;
   logic          z_ovf;
   logic          done;
`ifdef MBF_MERGE_CHECKSUM_EN
   logic [15:0]   out_sum;
`endif

   int checks = 0;
   int errors = 0;

   mbf_band_merge dut (
      .clk       (clk),
      .reset     (reset),
      .y_valid   (y_valid),
      .y         (y),
      .z_valid   (z_valid),
      .z         (z),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_band  (out_band),
      .out_idx   (out_idx),
      .y_ovf     (y_ovf),
      .z_ovf     (z_ovf),
      .done      (done)
`ifdef MBF_MERGE_CHECKSUM_EN
     ,.out_sum   (out_sum)
`endif
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_data"},  32'(out_data),  32'd0);
      chk({tag, "_band"},  32'(out_band),  32'd0);
      chk({tag, "_idx"},   32'(out_idx),   32'd0);
      chk({tag, "_yovf"},  32'(y_ovf),     32'd0);
      chk({tag, "_zovf"},  32'(z_ovf),     32'd0);
      chk({tag, "_done"},  32'(done),      32'd0);
   endtask

   task automatic chk_word(input string tag, input logic [7:0] d, input logic b, input int i);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_data"},  32'(out_data),  32'(d));
      chk({tag, "_band"},  32'(out_band),  32'(b));
      chk({tag, "_idx"},   32'(out_idx),   32'(i));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      y_valid = 1'b0; z_valid = 1'b0; y = '0; z = '0;
      step();
      step();
      reset = 1'b0;
   endtask

   logic [7:0] exp_data [6];
   int         k;
   int         w;
   logic [7:0] pb;
   logic       bb;
   bit         finished;

   initial begin
      out_ready = 1'b1;
      do_reset();
      chk_idle_outputs("reset");

      // Basic pair: y then z one cycle apart.
      step();
      y_valid = 1'b1; y = 8'h11;
      step();
      y_valid = 1'b0; z_valid = 1'b1; z = 8'h22;
      step();
      chk_word("pair_l", 8'h11, 1'b0, 0);
      z_valid = 1'b0;
      step();
      chk_word("pair_h", 8'h22, 1'b1, 0);
      step();
      chk("pair_drain_valid", 32'(out_valid), 32'd0);
      chk("pair_yovf", 32'(y_ovf), 32'd0);
      chk("pair_zovf", 32'(z_ovf), 32'd0);

      // HPF overflow while the selector waits for LPF.
      for (int i = 0; i < 5; i++) begin
         z_valid = 1'b1; z = 8'hA0 + 8'(i);
         step();
         chk("ovf_valid", 32'(out_valid), 32'd0);
         if (i == 3) chk("ovf_zovf_before", 32'(z_ovf), 32'd0);
      end
      z_valid = 1'b0;
      chk("ovf_zovf", 32'(z_ovf), 32'd1);
      y_valid = 1'b1; y = 8'h33;
      step();
      y_valid = 1'b0;
      step();
      chk_word("ovf_l", 8'h33, 1'b0, 1);
      step();
      chk_word("ovf_h", 8'hA0, 1'b1, 1);
      out_ready = 1'b0;
      step();
      chk_word("ovf_hold", 8'hA0, 1'b1, 1);

      // Reset with 3 words buffered and the output register full.
      reset = 1'b1;
      step();
      chk_idle_outputs("midrst");
      reset = 1'b0; out_ready = 1'b1;
      y_valid = 1'b1; y = 8'h55;
      step();
      y_valid = 1'b0;
      step();
      chk_word("midrst_l", 8'h55, 1'b0, 0);
      step();
      chk("midrst_no_stale", 32'(out_valid), 32'd0);

      // Back-pressure with out_ready pattern 1,0,0,1.
      do_reset();
      exp_data = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22};
      k = 0;
      for (int c = 0; c < 40; c++) begin
         y_valid = (c < 3); y = 8'h10 + 8'(c);
         z_valid = (c < 3); z = 8'h20 + 8'(c);
         out_ready = ((c % 4) == 0) || ((c % 4) == 3);
         if (out_valid) begin
            if (k < 6) begin
               chk_word("stall", exp_data[k], k[0], k / 2);
               if (out_ready) k++;
            end else begin
               chk("stall_extra_word", 32'(out_valid), 32'd0);
            end
         end
         step();
      end
      chk("stall_count", 32'(k), 32'd6);
      out_ready = 1'b1;
      y_valid = 1'b0; z_valid = 1'b0;

      // Full frame of N_PAIRS pairs.
      do_reset();
      w = 0;
      finished = 1'b0;
      for (int t = 0; t < 1200 && !finished; t++) begin
         y_valid = ((t % 2) == 0) && (t / 2 < N_PAIRS); y = 8'(t / 2);
         z_valid = ((t % 2) == 1) && (t / 2 < N_PAIRS); z = ~8'(t / 2);
         step();
         if (out_valid) begin
            pb = 8'(w / 2);
            bb = w[0];
            chk_word("frame", bb ? ~pb : pb, bb, w / 2);
            w++;
            if (w == 2 * N_PAIRS) finished = 1'b1;
         end
      end
      chk("frame_words", 32'(w), 32'(2 * N_PAIRS));
      chk("frame_last_idx", 32'(out_idx), 32'(N_PAIRS - 1));
      y_valid = 1'b0; z_valid = 1'b0;
      step();
      chk("frame_done_pending", 32'(done), 32'd0);
      chk("frame_valid_after", 32'(out_valid), 32'd0);
      step();
      chk("frame_done", 32'(done), 32'd1);
      chk("frame_zovf_clean", 32'(z_ovf), 32'd0);
      for (int i = 0; i < 5; i++) begin
         y_valid = 1'b1; y = 8'(i);
         z_valid = 1'b1; z = 8'(i);
         step();
         chk("frame_no_output", 32'(out_valid), 32'd0);
      end
      y_valid = 1'b0; z_valid = 1'b0;
      step();
      chk("frame_done_held", 32'(done), 32'd1);
      chk("frame_yovf", 32'(y_ovf), 32'd1);
      chk("frame_zovf", 32'(z_ovf), 32'd1);

`ifdef MBF_MERGE_CHECKSUM_EN
      do_reset();
      chk("sum_reset", 32'(out_sum), 32'd0);
      for (int t = 0; t < 4; t++) begin
         y_valid = ((t % 2) == 0); y = 8'hFF;
         z_valid = ((t % 2) == 1); z = 8'h01;
         step();
      end
      y_valid = 1'b0; z_valid = 1'b0;
      for (int t = 0; t < 4; t++) step();
      chk("sum_value", 32'(out_sum), 32'h0200);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
